// File: rtl/gate_reduce_pipe_pkg.sv
// Mode encoding and decode helpers shared by the pipelined gate reduction unit.
package gate_reduce_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_AND  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_OR   = 3'b001;
  localparam logic [MODE_W-1:0] MODE_XOR  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_NAND = 3'b011;
  localparam logic [MODE_W-1:0] MODE_NOR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_XNOR = 3'b101;

  typedef enum logic [1:0] {
    FN_AND = 2'd0,
    FN_OR  = 2'd1,
    FN_XOR = 2'd2
  } base_fn_e;

  typedef struct packed {
    base_fn_e fn;
    logic     inv;
    logic     illegal;
  } mode_dec_t;

  function automatic logic mode_illegal(input logic [MODE_W-1:0] mode);
    return (mode > MODE_XNOR);
  endfunction

  // Complement modes share the tree with their base function; inversion is a final-stage flag.
  function automatic mode_dec_t decode_mode(input logic [MODE_W-1:0] mode);
    mode_dec_t d;
    d.fn      = FN_AND;
    d.inv     = 1'b0;
    d.illegal = mode_illegal(mode);
    case (mode)
      MODE_OR:   d.fn = FN_OR;
      MODE_XOR:  d.fn = FN_XOR;
      MODE_NAND: d.inv = 1'b1;
      MODE_NOR:  begin d.fn = FN_OR;  d.inv = 1'b1; end
      MODE_XNOR: begin d.fn = FN_XOR; d.inv = 1'b1; end
      default:   d.fn = FN_AND;
    endcase
    return d;
  endfunction

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gate_reduce_pipe_stage.sv
// One registered level of the reduction tree: combines lane pairs (2j, 2j+1) and
// carries valid/mode alongside; the final level also applies inversion and illegal masking.
module reduce_stage
  import gate_reduce_pkg::*;
#(
  parameter int LANES_IN = 2,
  parameter int WIDTH    = 4,
  parameter bit FINAL    = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            adv_i,
  input  logic                            valid_i,
  input  logic [MODE_W-1:0]               mode_i,
  input  logic [LANES_IN*WIDTH-1:0]       data_i,
  output logic                            valid_o,
  output logic [MODE_W-1:0]               mode_o,
  output logic [(LANES_IN/2)*WIDTH-1:0]   data_o
);

  localparam int LANES_OUT = LANES_IN / 2;

  mode_dec_t                    dec;
  logic [WIDTH-1:0]             lane_a;
  logic [WIDTH-1:0]             lane_b;
  logic [WIDTH-1:0]             lane_r;
  logic [LANES_OUT*WIDTH-1:0]   data_d;

  logic                         valid_q;
  logic [MODE_W-1:0]            mode_q;
  logic [LANES_OUT*WIDTH-1:0]   data_q;

  always_comb begin
    dec    = decode_mode(mode_i);
    data_d = '0;
    lane_a = '0;
    lane_b = '0;
    lane_r = '0;
    for (int j = 0; j < LANES_OUT; j++) begin
      lane_a = data_i[(2*j)*WIDTH +: WIDTH];
      lane_b = data_i[(2*j+1)*WIDTH +: WIDTH];
      case (dec.fn)
        FN_OR:   lane_r = lane_a | lane_b;
        FN_XOR:  lane_r = lane_a ^ lane_b;
        default: lane_r = lane_a & lane_b;
      endcase
      if (FINAL) begin
        if (dec.illegal) begin
          lane_r = '0;
        end else if (dec.inv) begin
          lane_r = ~lane_r;
        end
      end
      data_d[j*WIDTH +: WIDTH] = lane_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= '0;
      data_q  <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      mode_q  <= mode_i;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign data_o  = data_q;

endmodule

// File: rtl/gate_reduce_pipe.sv
// Pipelined N-input bitwise reduction with run-time mode select and a ready/valid
// handshake; one global advance enable freezes every level while the output is stalled.
module gate_reduce_pipe
  import gate_reduce_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [MODE_W-1:0]       in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
);

  localparam int LEVELS = clog2(N_IN);

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    localparam int LIN = N_IN >> k;

    logic                        valid_in;
    logic [MODE_W-1:0]           mode_in;
    logic [LIN*WIDTH-1:0]        data_in;
    logic                        valid_s;
    logic [MODE_W-1:0]           mode_s;
    logic [(LIN/2)*WIDTH-1:0]    data_s;

    // Bubbles enter as valid = 0 whenever the pipe advances without an input.
    if (k == 0) begin : g_head
      assign valid_in = in_valid;
      assign mode_in  = in_mode;
      assign data_in  = in_data;
    end else begin : g_link
      assign valid_in = g_stage[k-1].valid_s;
      assign mode_in  = g_stage[k-1].mode_s;
      assign data_in  = g_stage[k-1].data_s;
    end

    reduce_stage #(
      .LANES_IN (LIN),
      .WIDTH    (WIDTH),
      .FINAL    (k == LEVELS - 1)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv_i   (adv),
      .valid_i (valid_in),
      .mode_i  (mode_in),
      .data_i  (data_in),
      .valid_o (valid_s),
      .mode_o  (mode_s),
      .data_o  (data_s)
    );
  end

  assign out_valid = g_stage[LEVELS-1].valid_s;
  assign out_data  = g_stage[LEVELS-1].data_s;
  assign out_err   = mode_illegal(g_stage[LEVELS-1].mode_s);

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Bench for gate_reduce_pipe: directed table on a 4x4 instance, stall and reset
// sequences, and randomized traffic on an 8x1 instance against a fold-based model.
module tb_gate_reduce_pipe;

  localparam int NA = 4, WA = 4, LVA = 2;
  localparam int NB = 8, WB = 1, LVB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [NA*WA-1:0]  a_in_data;
  logic [2:0]        a_in_mode;
  logic [WA-1:0]     a_out_data;

  logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [NB*WB-1:0]  b_in_data;
  logic [2:0]        b_in_mode;
  logic [WB-1:0]     b_out_data;

  gate_reduce_pipe #(.N_IN(NA), .WIDTH(WA)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err)
  );

  gate_reduce_pipe #(.N_IN(NB), .WIDTH(WB)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Linear fold over lanes; complement applied once at the end; illegal modes give err.
  function automatic logic [4:0] ref_reduce(input logic [31:0] data, input int n,
                                            input int w, input logic [2:0] mode);
    logic [3:0] mask, acc, lane;
    int m;
    mask = 4'((5'd1 << w) - 5'd1);
    if (mode > 3'd5) return 5'b1_0000;
    m = int'(mode) % 3;
    acc = 4'(data) & mask;
    for (int i = 1; i < n; i++) begin
      lane = 4'(data >> (i * w)) & mask;
      if (m == 0)      acc = acc & lane;
      else if (m == 1) acc = acc | lane;
      else             acc = acc ^ lane;
    end
    if (mode >= 3'd3) acc = ~acc & mask;
    return {1'b0, acc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [4:0] res;
    int         acc_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  bit   lat_exact_b = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_out_valid && a_out_ready) begin
        chk("a_result_expected", (q_a.size() != 0), 1);
        if (q_a.size() != 0) begin
          ea = q_a.pop_front();
          chk("a_sb_data", a_out_data, ea.res[3:0]);
          chk("a_sb_err", a_out_err, ea.res[4]);
        end
      end
      if (a_in_valid && a_in_ready)
        q_a.push_back('{res: ref_reduce(a_in_data, NA, WA, a_in_mode), acc_cyc: cyc});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_out_valid && b_out_ready) begin
        chk("b_result_expected", (q_b.size() != 0), 1);
        if (q_b.size() != 0) begin
          eb = q_b.pop_front();
          chk("b_sb_data", b_out_data, eb.res[0]);
          chk("b_sb_err", b_out_err, eb.res[4]);
          if (lat_exact_b) chk("b_latency", cyc - eb.acc_cyc, LVB);
          else             chk("b_latency_min", (cyc - eb.acc_cyc) >= LVB, 1);
        end
      end
      if (b_in_valid && b_in_ready)
        q_b.push_back('{res: ref_reduce(b_in_data, NB, WB, b_in_mode), acc_cyc: cyc});
    end
  end

  task automatic drain_a(input int budget);
    int n = 0;
    while (q_a.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("a_drain_empty", q_a.size(), 0);
  endtask

  task automatic drain_b(input int budget);
    int n = 0;
    while (q_b.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("b_drain_empty", q_b.size(), 0);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [2:0]  mode;
    logic [3:0]  exp_d;
    logic        exp_e;
  } vec_t;

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    vec_t       tbl[10];
    logic [4:0] e0;

    a_in_valid = 0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1;

    // lanes {1,2,4,8} packed lane0 in the low nibble
    tbl[0] = '{16'h8421, 3'b001, 4'hF, 1'b0};
    tbl[1] = '{16'h8421, 3'b000, 4'h0, 1'b0};
    tbl[2] = '{16'h8421, 3'b010, 4'hF, 1'b0};
    tbl[3] = '{16'h8421, 3'b011, 4'hF, 1'b0};
    tbl[4] = '{16'h8421, 3'b100, 4'h0, 1'b0};
    tbl[5] = '{16'h8421, 3'b101, 4'h0, 1'b0};
    tbl[6] = '{16'hFFFF, 3'b110, 4'h0, 1'b1};
    tbl[7] = '{16'h3C5A, 3'b111, 4'h0, 1'b1};
    tbl[8] = '{16'hFFFF, 3'b000, 4'hF, 1'b0};
    tbl[9] = '{16'h1234, 3'b010, 4'h4, 1'b0};

    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_out_err", a_out_err, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);

    // back-to-back table, result exactly LVA cycles after each input cycle
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c < 10) begin
        a_in_valid = 1; a_in_data = tbl[c].data; a_in_mode = tbl[c].mode;
      end else begin
        a_in_valid = 0;
      end
      @(negedge clk);
      if (c >= LVA) begin
        chk($sformatf("tbl%0d_valid", c - LVA), a_out_valid, 1);
        chk($sformatf("tbl%0d_data", c - LVA), a_out_data, tbl[c-LVA].exp_d);
        chk($sformatf("tbl%0d_err", c - LVA), a_out_err, tbl[c-LVA].exp_e);
      end else begin
        chk("tbl_early_valid", a_out_valid, 0);
      end
    end
    drain_a(20);

    // stall: fill with two, hold a third at the input for six frozen cycles
    @(posedge clk); #1;
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 16'($urandom); a_in_mode = 3'($urandom_range(0, 5));
    e0 = ref_reduce(a_in_data, NA, WA, a_in_mode);
    @(posedge clk); #1;
    a_in_data = 16'($urandom); a_in_mode = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    a_in_data = 16'($urandom); a_in_mode = 3'($urandom_range(0, 7));
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", a_in_ready, 0);
      chk("stall_out_valid", a_out_valid, 1);
      chk("stall_out_data", a_out_data, e0[3:0]);
      chk("stall_q_depth", q_a.size(), 2);
    end
    @(posedge clk); #1;
    a_out_ready = 1;
    @(posedge clk); #1;
    a_in_valid = 0;
    drain_a(20);

    // reset with two transactions in flight
    @(posedge clk); #1;
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 16'hFFFF; a_in_mode = 3'b000;
    @(posedge clk); #1;
    a_in_data = 16'h0001; a_in_mode = 3'b001;
    @(posedge clk); #1;
    a_in_valid = 0;
    @(negedge clk);
    chk("pre_rst_out_valid", a_out_valid, 1);
    chk("pre_rst_out_data", a_out_data, 4'hF);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("rst_pulse_out_valid", a_out_valid, 0);
    chk("rst_pulse_out_data", a_out_data, 0);
    chk("rst_pulse_out_err", a_out_err, 0);
    chk("rst_pulse_in_ready", a_in_ready, 1);
    q_a.delete();
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
    a_out_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_stale", a_out_valid, 0);
    end
    @(posedge clk); #1;
    a_in_valid = 1; a_in_data = 16'($urandom); a_in_mode = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    a_in_valid = 0;
    drain_a(20);

    // 8x1: unstalled random traffic, then random backpressure
    lat_exact_b = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      b_in_valid = ($urandom_range(0, 3) != 0);
      b_in_data  = 8'($urandom);
      b_in_mode  = 3'($urandom_range(0, 7));
    end
    @(posedge clk); #1;
    b_in_valid = 0;
    drain_b(20);
    lat_exact_b = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_data   = 8'($urandom);
      b_in_mode   = 3'($urandom_range(0, 7));
      b_out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    b_in_valid = 0;
    b_out_ready = 1;
    drain_b(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
